// File: rtl/key_expand_128.sv
// Sequential AES-128 key expansion: emits round keys 0..10, one per cycle, into a
// hi/lo pair of 16x64 round-key RAMs. SubWord is done by an external S-box.
module key_expand_128 #(
  parameter logic [3:0] BASE_ADDR = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         wr,
  output logic [3:0]   wr_addr,
  output logic [63:0]  wr_data_hi,
  output logic [63:0]  wr_data_lo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   cur_key_q, cur_key_d;
  logic [7:0]     rcon_q, rcon_d;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    t, n0, n1, n2, n3;
  logic           expand;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  assign {w0, w1, w2, w3} = cur_key_q;

  // Chained XOR form of the FIPS-197 recurrence: each new word folds in the previous new word.
  assign t  = sbox_out ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rnd_q     <= 4'd0;
      cur_key_q <= 128'd0;
      rcon_q    <= 8'h01;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      cur_key_q <= cur_key_d;
      rcon_q    <= rcon_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    cur_key_d = cur_key_q;
    rcon_d    = rcon_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_key_d = key;
          rnd_d     = 4'd0;
          rcon_d    = 8'h01;
          state_d   = EXPAND;
        end
      end
      EXPAND: begin
        if (rnd_q == 4'd10) begin
          state_d = DONE;
        end else begin
          cur_key_d = {n0, n1, n2, n3};
          rnd_d     = rnd_q + 4'd1;
          rcon_d    = xtime(rcon_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs come straight from registers so consecutive writes have no gaps.
  assign expand     = (state_q == EXPAND);
  assign busy       = expand;
  assign wr         = expand;
  assign done       = (state_q == DONE);
  assign wr_addr    = expand ? (BASE_ADDR + rnd_q) : 4'd0;
  assign wr_data_hi = expand ? cur_key_q[127:64] : 64'd0;
  assign wr_data_lo = expand ? cur_key_q[63:0]   : 64'd0;
  assign sbox_in    = rot_word(w3);

endmodule

// File: tb/tb_key_expand_128.sv
// Bench for key_expand_128: S-box built from GF(2^8) inversion plus affine map, and a
// word-by-word FIPS-197 key schedule as the reference for every write.
module tb_key_expand_128;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key;
  logic         busy0, done0, wr0, busy8, done8, wr8;
  logic [31:0]  sbin0, sbout0, sbin8, sbout8;
  logic [3:0]   addr0, addr8;
  logic [63:0]  hi0, lo0, hi8, lo8;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  int           n_tests = 0;
  int           n_fail  = 0;

  logic         obs_wr [14], obs_busy [14], obs_done [14];
  logic [3:0]   obs_addr0 [14], obs_addr8 [14];
  logic [127:0] obs_data0 [14], obs_data8 [14];
  logic [31:0]  obs_sbin [14];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  assign sbout0 = {sb[sbin0[31:24]], sb[sbin0[23:16]], sb[sbin0[15:8]], sb[sbin0[7:0]]};
  assign sbout8 = {sb[sbin8[31:24]], sb[sbin8[23:16]], sb[sbin8[15:8]], sb[sbin8[7:0]]};

  key_expand_128 #(.BASE_ADDR(4'd0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy0), .done(done0),
    .sbox_in(sbin0), .sbox_out(sbout0), .wr(wr0), .wr_addr(addr0),
    .wr_data_hi(hi0), .wr_data_lo(lo0)
  );

  key_expand_128 #(.BASE_ADDR(4'd8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy8), .done(done8),
    .sbox_in(sbin8), .sbox_out(sbout8), .wr(wr8), .wr_addr(addr8),
    .wr_data_hi(hi8), .wr_data_lo(lo8)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one expansion (start sampled at edge T) and records cycles T+1..T+13.
  task automatic run_capture(input logic [127:0] k, input int pulse_at, input int rst_at);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
    key   = ~k;
    for (int c = 1; c <= 13; c++) begin
      obs_wr[c]    = wr0;
      obs_busy[c]  = busy0;
      obs_done[c]  = done0 | done8;
      obs_addr0[c] = addr0;
      obs_addr8[c] = addr8;
      obs_data0[c] = {hi0, lo0};
      obs_data8[c] = {hi8, lo8};
      obs_sbin[c]  = sbin0;
      start = (c == pulse_at);
      rst   = (c == rst_at);
      step();
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = 128'h0;
    step();
    n_tests++; if ({busy0, busy8} !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b want 00", {busy0, busy8}); end
    n_tests++; if ({done0, done8} !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", {done0, done8}); end
    n_tests++; if ({wr0, wr8} !== 2'b00) begin n_fail++; $display("FAIL reset_wr got %b want 00", {wr0, wr8}); end
    n_tests++; if ({addr0, addr8} !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", {addr0, addr8}); end
    n_tests++; if ({hi0, lo0, hi8, lo8} !== 256'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {hi0, lo0}); end
    n_tests++; if ({sbin0, sbin8} !== 64'h0) begin n_fail++; $display("FAIL reset_sbox_in got %h want 0", {sbin0, sbin8}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_key(input string name, input logic [127:0] k);
    model_expand(k);
    run_capture(k, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      n_tests++; if (obs_wr[c] !== (c <= 11)) begin n_fail++; $display("FAIL %s_wr c%0d got %b want %b", name, c, obs_wr[c], c <= 11); end
      n_tests++; if (obs_busy[c] !== (c <= 11)) begin n_fail++; $display("FAIL %s_busy c%0d got %b want %b", name, c, obs_busy[c], c <= 11); end
      n_tests++; if (obs_done[c] !== (c == 12)) begin n_fail++; $display("FAIL %s_done c%0d got %b want %b", name, c, obs_done[c], c == 12); end
    end
    for (int r = 0; r <= 10; r++) begin
      n_tests++; if (obs_addr0[r+1] !== 4'(r)) begin n_fail++; $display("FAIL %s_addr r%0d got %0d want %0d", name, r, obs_addr0[r+1], r); end
      n_tests++; if (obs_data0[r+1] !== exp_rk[r]) begin n_fail++; $display("FAIL %s_data r%0d got %h want %h", name, r, obs_data0[r+1], exp_rk[r]); end
      n_tests++; if (obs_sbin[r+1] !== {exp_rk[r][23:0], exp_rk[r][31:24]}) begin n_fail++; $display("FAIL %s_sbox_in r%0d got %h want %h", name, r, obs_sbin[r+1], {exp_rk[r][23:0], exp_rk[r][31:24]}); end
    end
  endtask

  task automatic test_fips();
    test_key("fips", FIPS_KEY);
    n_tests++; if (obs_data0[1] !== FIPS_KEY) begin n_fail++; $display("FAIL fips_addr0 got %h want %h", obs_data0[1], FIPS_KEY); end
    n_tests++; if (obs_data0[2] !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL fips_addr1 got %h want a0fafe1788542cb123a339392a6c7605", obs_data0[2]); end
    n_tests++; if (obs_data0[11] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL fips_addr10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_data0[11]); end
  endtask

  task automatic test_zero_key();
    test_key("zero", 128'h0);
    n_tests++; if (obs_data0[2] !== 128'h62636363626363636263636362636363) begin n_fail++; $display("FAIL zero_addr1 got %h want 62636363626363636263636362636363", obs_data0[2]); end
    n_tests++; if (obs_data0[11] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_fail++; $display("FAIL zero_addr10 got %h want b4ef5bcb3e92e21123e951cf6f8f188e", obs_data0[11]); end
  endtask

  task automatic test_random_keys();
    for (int i = 0; i < 4; i++)
      test_key("rand", {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic test_addr_wrap();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    run_capture(k, 0, 0);
    for (int r = 0; r <= 10; r++) begin
      n_tests++; if (obs_addr8[r+1] !== 4'((8 + r) % 16)) begin n_fail++; $display("FAIL wrap_addr r%0d got %0d want %0d", r, obs_addr8[r+1], (8 + r) % 16); end
      n_tests++; if (obs_data8[r+1] !== exp_rk[r]) begin n_fail++; $display("FAIL wrap_data r%0d got %h want %h", r, obs_data8[r+1], exp_rk[r]); end
    end
    n_tests++; if (obs_addr8[11] !== 4'd2) begin n_fail++; $display("FAIL wrap_last_addr got %0d want 2", obs_addr8[11]); end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    run_capture(k, 5, 0);
    for (int c = 1; c <= 13; c++) begin
      n_tests++; if (obs_wr[c] !== (c <= 11)) begin n_fail++; $display("FAIL busy_start_wr c%0d got %b want %b", c, obs_wr[c], c <= 11); end
      n_tests++; if (obs_done[c] !== (c == 12)) begin n_fail++; $display("FAIL busy_start_done c%0d got %b want %b", c, obs_done[c], c == 12); end
    end
    for (int r = 0; r <= 10; r++) begin
      n_tests++; if ({obs_addr0[r+1], obs_data0[r+1]} !== {4'(r), exp_rk[r]}) begin n_fail++; $display("FAIL busy_start_write r%0d got %h want %h", r, obs_data0[r+1], exp_rk[r]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    run_capture(k, 0, 6);
    for (int c = 1; c <= 13; c++) begin
      n_tests++; if (obs_wr[c] !== (c <= 6)) begin n_fail++; $display("FAIL rstmid_wr c%0d got %b want %b", c, obs_wr[c], c <= 6); end
      n_tests++; if (obs_busy[c] !== (c <= 6)) begin n_fail++; $display("FAIL rstmid_busy c%0d got %b want %b", c, obs_busy[c], c <= 6); end
      n_tests++; if (obs_done[c] !== 1'b0) begin n_fail++; $display("FAIL rstmid_done c%0d got %b want 0", c, obs_done[c]); end
    end
    test_key("after_rst", ~k);
  endtask

  task automatic test_rst_and_start();
    rst = 1'b1; start = 1'b1; key = {$urandom, $urandom, $urandom, $urandom};
    step();
    n_tests++; if ({wr0, busy0} !== 2'b00) begin n_fail++; $display("FAIL rst_start_wr got %b want 00", {wr0, busy0}); end
    rst = 1'b0; start = 1'b0;
    step();
    n_tests++; if ({wr0, busy0, done0} !== 3'b000) begin n_fail++; $display("FAIL rst_start_idle got %b want 000", {wr0, busy0, done0}); end
  endtask

  task automatic test_back_to_back();
    logic         bw [27];
    logic         bd [27];
    logic [127:0] bdat [27];
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    key = k; start = 1'b1;
    step();
    for (int c = 1; c <= 26; c++) begin
      bw[c] = wr0; bd[c] = done0; bdat[c] = {hi0, lo0};
      step();
    end
    start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      n_tests++; if (bw[c] !== (((c - 1) % 13) < 11)) begin n_fail++; $display("FAIL b2b_wr c%0d got %b want %b", c, bw[c], ((c - 1) % 13) < 11); end
      n_tests++; if (bd[c] !== (c == 12 || c == 25)) begin n_fail++; $display("FAIL b2b_done c%0d got %b want %b", c, bd[c], c == 12 || c == 25); end
    end
    for (int r = 0; r <= 10; r++) begin
      n_tests++; if (bdat[r+1] !== exp_rk[r]) begin n_fail++; $display("FAIL b2b_run1 r%0d got %h want %h", r, bdat[r+1], exp_rk[r]); end
      n_tests++; if (bdat[r+14] !== exp_rk[r]) begin n_fail++; $display("FAIL b2b_run2 r%0d got %h want %h", r, bdat[r+14], exp_rk[r]); end
    end
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = 128'h0;
    build_sbox();
    step();
    test_reset();
    test_fips();
    test_zero_key();
    test_random_keys();
    test_addr_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_rst_and_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand_128.md
Name: key_expand_128

Overview:
- Sequential AES-128 key-expansion engine that generates the 11 round keys from a 128-bit cipher key.
- Writes one round key per cycle into the round-key store, which is a pair of 16x64 register-file RAMs: hi = bits 127:64, lo = bits 63:0, with shared write address and write enable.
- Sits directly upstream of the round-key RAMs. The cipher datapath reads those RAMs once done is seen.
- S-box is external: a shared combinational 4-byte substitution unit, so this block holds no lookup tables.

Parameters:
- BASE_ADDR, default 4'd0: RAM address of round key 0. Round r is written at (BASE_ADDR + r) mod 16.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request expansion of key; sampled only in IDLE.
- key, input, 128: cipher key; key[127:96] = w0 … key[31:0] = w3 (FIPS-197 byte order, MSB first).
- busy, output, 1: high while round keys are being written.
- done, output, 1: one-cycle pulse after the last write.
- sbox_in, output, 32: RotWord of current w3, i.e. {w3[23:0], w3[31:24]}.
- sbox_out, input, 32: bytewise S-box of sbox_in; combinational, same cycle.
- wr, output, 1: RAM write enable.
- wr_addr, output, 4: RAM write address.
- wr_data_hi, output, 64: round key bits 127:64.
- wr_data_lo, output, 64: round key bits 63:0.

Behaviour:
- States: IDLE, EXPAND, DONE.
- Registers: state, rnd (4 bits), cur_key (128 bits), rcon (8 bits).
- Reset (rst=1 at an edge): state=IDLE, rnd=0, cur_key=0, rcon=8'h01.
  - All outputs are 0 the cycle after reset: busy, done, wr, wr_addr, wr_data_*, sbox_in. sbox_in=0 follows from cur_key=0.
  - rst has priority over start.
- IDLE, start=1 at edge T: cur_key<=key, rnd<=0, rcon<=8'h01, state<=EXPAND. start=0: remain in IDLE.
- EXPAND, cycles T+1 … T+11:
  - busy=1, wr=1.
  - wr_addr = BASE_ADDR + rnd, truncated to 4 bits (wraps past 15).
  - {wr_data_hi, wr_data_lo} = cur_key.
  - Outputs are combinational from registers, so there are no RAM-side pipeline bubbles.
- Next-key logic (combinational), with cur_key = {w0,w1,w2,w3}:
  - t = sbox_out ^ {rcon, 24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
- Each EXPAND edge with rnd<10: cur_key <= {n0,n1,n2,n3}, rnd <= rnd+1, rcon <= xtime(rcon).
  - xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- EXPAND edge with rnd==10: state<=DONE. Exactly 11 writes occur, round 0 = key itself.
- DONE, cycle T+12: done=1, busy=0, wr=0. Next edge: state<=IDLE.
- Latency: start edge to first write is 1 cycle; start edge to done is 12 cycles. A new start is accepted at the earliest in cycle T+13, i.e. sampled at the edge ending that IDLE cycle.
- start while busy or in DONE: ignored, no effect.
- key is only sampled at the accepting edge. Later changes to key do not affect an in-flight expansion.
- Reset mid-EXPAND: no further writes and no done pulse. RAM contents already written are left as is, and are incomplete.
- sbox_out is ignored outside EXPAND. sbox_in is always RotWord(cur_key[31:0]).
- Back-to-back: start held high continuously gives a run every 13 cycles with identical write sequences.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, BASE_ADDR=0, bench S-box model:
  - addr0 = key
  - addr1 = a0fafe1788542cb123a339392a6c7605
  - addr10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses exactly at T+12; 11 writes total.
- All-zero key:
  - addr1 = 62636363626363636263636362636363
  - addr10 = b4ef5bcb3e92e21123e951cf6f8f188e
- BASE_ADDR=8: writes land at addresses 8..15 then 0,1,2 (wrap); address 2 holds round 10.
- start pulsed at T+5 during busy, with key changed: write sequence and data identical to the undisturbed run; a single done at T+12.
- rst asserted at T+6:
  - wr=0 and busy=0 from T+7; no done ever asserted.
  - A subsequent start yields the full correct 11-write sequence.
- rst and start both high at the same edge: block stays in IDLE, wr=0 the following cycle.
